// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage of the five-stage LoongArch-subset pipeline. It
// sits between execute and writeback: it registers the execute-to-memory
// bus and captures the synchronous data-SRAM read data. If writeback
// stalls, it holds that read data in a local buffer. It then aligns and
// sign/zero-extends load data, forwards the result to decode, and flags
// exceptions or ertn back to execute so that younger stores are
// suppressed.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   ws_allowin        writeback can accept an instruction
//   ms_allowin        this stage can accept an instruction
//   es_to_ms_valid    execute offers an instruction
//   es_to_ms_bus      execute-to-memory bus (ES_BUS_W bits)
//   data_sram_rdata   SRAM read data, valid in the instruction's first cycle here
//   ms_to_ws_valid    offer to writeback
//   ms_to_ws_bus      memory-to-writeback bus (MS_BUS_W bits)
//   ms_to_ds_dest     bypass destination register, 0 when none
//   ms_to_ds_value    bypass value (final result, including load data)
//   ms_csr            valid CSR read/write in stage (decode interlock)
//   ms_int            valid instruction carrying an exception or ertn
//   ws_reflush_ms     flush request from writeback
module mem_stage #(
    parameter int ES_BUS_W = 143,
    parameter int MS_BUS_W = 169
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ws_allowin,
    output logic                ms_allowin,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    input  logic [31:0]         data_sram_rdata,
    output logic                ms_to_ws_valid,
    output logic [MS_BUS_W-1:0] ms_to_ws_bus,
    output logic [4:0]          ms_to_ds_dest,
    output logic [31:0]         ms_to_ds_value,
    output logic                ms_csr,
    output logic                ms_int,
    input  logic                ws_reflush_ms
);

    logic                ms_valid;
    logic                ms_ready_go;
    logic [ES_BUS_W-1:0] ms_bus;
    logic                ms_first;
    logic [31:0]         rdata_buf;
    logic                buf_valid;
    logic                enter;
    logic                leave;

    logic        f_rdcntid;
    logic        f_ertn;
    logic        f_csr_we;
    logic        f_csr_rd;
    logic [31:0] f_csr_wmask;
    logic [13:0] f_csr_num;
    logic [16:0] f_ex_cause;
    logic [4:0]  f_ld_op;
    logic        f_res_from_mem;
    logic        f_gr_we;
    logic [4:0]  f_dest;
    logic [31:0] f_alu_result;
    logic [31:0] f_pc;

    logic [31:0] load_src;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] final_result;
    logic        gr_we_final;

    assign f_rdcntid      = ms_bus[142];
    assign f_ertn         = ms_bus[141];
    assign f_csr_we       = ms_bus[140];
    assign f_csr_rd       = ms_bus[139];
    assign f_csr_wmask    = ms_bus[138:107];
    assign f_csr_num      = ms_bus[106:93];
    assign f_ex_cause     = ms_bus[92:76];
    assign f_ld_op        = ms_bus[75:71];
    assign f_res_from_mem = ms_bus[70];
    assign f_gr_we        = ms_bus[69];
    assign f_dest         = ms_bus[68:64];
    assign f_alu_result   = ms_bus[63:32];
    assign f_pc           = ms_bus[31:0];

    // The stage never waits on memory: the SRAM answers in one cycle.
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && !ws_reflush_ms;
    assign enter          = es_to_ms_valid && ms_allowin;
    assign leave          = ms_valid && ms_ready_go && ws_allowin;

    // Valid bit: a flush from writeback overrides any new entry.
    always_ff @(posedge clk) begin
        if (reset || ws_reflush_ms) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Bus register has no reset; its contents are ignored while invalid.
    always_ff @(posedge clk) begin
        if (enter) begin
            ms_bus <= es_to_ms_bus;
        end
    end

    // The SRAM read data is only valid during the first cycle an
    // instruction spends here. If writeback is stalled in that cycle,
    // the data is saved so the result stays stable until the stage drains.
    // A simultaneous leave and entry clears buf_valid, so the new
    // instruction starts with no buffered data.
    always_ff @(posedge clk) begin
        if (reset || ws_reflush_ms) begin
            ms_first  <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            ms_first <= enter;
            if (leave) begin
                buf_valid <= 1'b0;
            end else if (ms_first && ms_valid && f_res_from_mem && !ws_allowin) begin
                buf_valid <= 1'b1;
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign load_src = buf_valid ? rdata_buf : data_sram_rdata;

    // Load alignment and extension, selected by the low address bits.
    always_comb begin
        byte_val = load_src[7:0];
        case (f_alu_result[1:0])
            2'd0: byte_val = load_src[7:0];
            2'd1: byte_val = load_src[15:8];
            2'd2: byte_val = load_src[23:16];
            2'd3: byte_val = load_src[31:24];
            default: byte_val = load_src[7:0];
        endcase
        half_val = f_alu_result[1] ? load_src[31:16] : load_src[15:0];

        load_val = load_src;
        if (f_ld_op[0]) begin
            load_val = {{24{byte_val[7]}}, byte_val};
        end else if (f_ld_op[1]) begin
            load_val = {24'd0, byte_val};
        end else if (f_ld_op[2]) begin
            load_val = {{16{half_val[15]}}, half_val};
        end else if (f_ld_op[3]) begin
            load_val = {16'd0, half_val};
        end
    end

    assign final_result = f_res_from_mem ? load_val : f_alu_result;

    // Belt-and-braces: an excepting instruction never writes a GPR.
    assign gr_we_final = f_gr_we && !(|f_ex_cause);

    assign ms_to_ws_bus = {f_rdcntid, f_ertn, f_csr_we, f_csr_rd, f_csr_wmask,
                           f_csr_num, f_ex_cause, f_alu_result, gr_we_final,
                           f_dest, final_result, f_pc};

    assign ms_to_ds_dest  = (ms_valid && gr_we_final) ? f_dest : 5'd0;
    assign ms_to_ds_value = final_result;
    assign ms_csr         = ms_valid && (f_csr_we || f_csr_rd);
    // This signal is combinational so that execute can drop a younger
    // store in the same cycle.
    assign ms_int         = ms_valid && ((|f_ex_cause) || f_ertn);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed testbench for mem_stage. Each task drives one scenario and
// compares the outputs against hand-computed values. Inputs change 1 ns
// after the rising edge. Outputs are sampled 1 ns after that, well away
// from the clock edge.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [142:0] es_to_ms_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [168:0] ms_to_ws_bus;
    logic [4:0]   ms_to_ds_dest;
    logic [31:0]  ms_to_ds_value;
    logic         ms_csr;
    logic         ms_int;
    logic         ws_reflush_ms;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .data_sram_rdata(data_sram_rdata),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_to_ds_dest  (ms_to_ds_dest),
        .ms_to_ds_value (ms_to_ds_value),
        .ms_csr         (ms_csr),
        .ms_int         (ms_int),
        .ws_reflush_ms  (ws_reflush_ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs an execute-to-memory bus word.
    function automatic logic [142:0] make_bus(input logic [4:0] ld_op, input logic rfm,
                                              input logic gr_we, input logic [4:0] dest,
                                              input logic [31:0] alu, input logic [31:0] pc,
                                              input logic [16:0] exc, input logic ertn,
                                              input logic csr_rd);
        return {1'b0, ertn, 1'b0, csr_rd, 32'd0, 14'h5, exc, ld_op, rfm, gr_we, dest, alu, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ws_valid got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_to_ds_dest !== 5'd0) begin errors++; $display("[TB] FAIL reset_ds_dest got %0d want 0", ms_to_ds_dest); end
        checks++; if (ms_int !== 1'b0) begin errors++; $display("[TB] FAIL reset_int got %b want 0", ms_int); end
        checks++; if (ms_csr !== 1'b0) begin errors++; $display("[TB] FAIL reset_csr got %b want 0", ms_csr); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("[TB] FAIL reset_allowin got %b want 1", ms_allowin); end
    endtask

    task automatic test_load_word();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(5'b10000, 1'b1, 1'b1, 5'd5, 32'h0000_1000, 32'h1C00_0010, 17'd0, 1'b0, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("[TB] FAIL ldw_valid got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ldw_result got %h want deadbeef", ms_to_ws_bus[63:32]); end
        checks++; if (ms_to_ds_dest !== 5'd5) begin errors++; $display("[TB] FAIL ldw_ds_dest got %0d want 5", ms_to_ds_dest); end
        checks++; if (ms_to_ds_value !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ldw_ds_value got %h want deadbeef", ms_to_ds_value); end
        checks++; if (ms_to_ws_bus[101:70] !== 32'h0000_1000) begin errors++; $display("[TB] FAIL ldw_vaddr got %h want 00001000", ms_to_ws_bus[101:70]); end
        checks++; if (ms_to_ws_bus[31:0] !== 32'h1C00_0010) begin errors++; $display("[TB] FAIL ldw_pc got %h want 1c000010", ms_to_ws_bus[31:0]); end
        checks++; if (ms_to_ws_bus[69] !== 1'b1) begin errors++; $display("[TB] FAIL ldw_gr_we got %b want 1", ms_to_ws_bus[69]); end
        step();
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("[TB] FAIL ldw_drain got %b want 0", ms_to_ws_valid); end
    endtask

    task automatic test_load_align();
        logic [4:0]  ops  [7] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00001, 5'b00100, 5'b00010};
        logic [31:0] addrs[7] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002, 32'h2000, 32'h2000, 32'h2001};
        logic [31:0] rds  [7] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                                  32'h1234_5687, 32'h1234_5687, 32'h1234_5687};
        logic [31:0] exps [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                  32'hFFFF_FF87, 32'h0000_5687, 32'h0000_0056};
        ws_allowin = 1'b1;
        for (int i = 0; i < 7; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = make_bus(ops[i], 1'b1, 1'b1, 5'd6, addrs[i], 32'h1C00_0100, 17'd0, 1'b0, 1'b0);
            step();
            es_to_ms_valid  = 1'b0;
            data_sram_rdata = rds[i];
            #1;
            checks++;
            if (ms_to_ws_bus[63:32] !== exps[i]) begin
                errors++;
                $display("[TB] FAIL align_%0d got %h want %h", i, ms_to_ws_bus[63:32], exps[i]);
            end
        end
        step();
    endtask

    task automatic test_stall();
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(5'b10000, 1'b1, 1'b1, 5'd7, 32'h0000_3000, 32'h1C00_0200, 17'd0, 1'b0, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("[TB] FAIL stall_allowin_c1 got %b want 0", ms_allowin); end
        checks++; if (ms_to_ws_bus[63:32] !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL stall_result_c1 got %h want cafef00d", ms_to_ws_bus[63:32]); end
        for (int c = 2; c <= 3; c++) begin
            step();
            data_sram_rdata = 32'h0;
            #1;
            checks++; if (ms_allowin !== 1'b0) begin errors++; $display("[TB] FAIL stall_allowin_c%0d got %b want 0", c, ms_allowin); end
            checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid_c%0d got %b want 1", c, ms_to_ws_valid); end
            checks++; if (ms_to_ws_bus[63:32] !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL stall_result_c%0d got %h want cafef00d", c, ms_to_ws_bus[63:32]); end
        end
        step();
        ws_allowin = 1'b1;
        #1;
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_allowin got %b want 1", ms_allowin); end
        checks++; if (ms_to_ds_value !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL stall_release_value got %h want cafef00d", ms_to_ds_value); end
        step();
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got %b want 0", ms_to_ws_valid); end
    endtask

    task automatic test_exception();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(5'b10000, 1'b0, 1'b1, 5'd9, 32'h0000_4001, 32'h1C00_0300, 17'h8, 1'b0, 1'b0);
        step();
        es_to_ms_bus = make_bus(5'b00000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0304, 17'd0, 1'b1, 1'b0);
        #1;
        checks++; if (ms_int !== 1'b1) begin errors++; $display("[TB] FAIL exc_int got %b want 1", ms_int); end
        checks++; if (ms_to_ws_bus[69] !== 1'b0) begin errors++; $display("[TB] FAIL exc_gr_we got %b want 0", ms_to_ws_bus[69]); end
        checks++; if (ms_to_ds_dest !== 5'd0) begin errors++; $display("[TB] FAIL exc_ds_dest got %0d want 0", ms_to_ds_dest); end
        checks++; if (ms_to_ws_bus[101:70] !== 32'h0000_4001) begin errors++; $display("[TB] FAIL exc_vaddr got %h want 00004001", ms_to_ws_bus[101:70]); end
        checks++; if (ms_to_ws_bus[118:102] !== 17'h8) begin errors++; $display("[TB] FAIL exc_cause got %h want 8", ms_to_ws_bus[118:102]); end
        step();
        es_to_ms_valid = 1'b0;
        #1;
        checks++; if (ms_int !== 1'b1) begin errors++; $display("[TB] FAIL ertn_int got %b want 1", ms_int); end
        checks++; if (ms_to_ws_bus[167] !== 1'b1) begin errors++; $display("[TB] FAIL ertn_flag got %b want 1", ms_to_ws_bus[167]); end
        step();
        checks++; if (ms_int !== 1'b0) begin errors++; $display("[TB] FAIL exc_drain_int got %b want 0", ms_int); end
    endtask

    task automatic test_flush();
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(5'b10000, 1'b1, 1'b1, 5'd3, 32'h0000_5000, 32'h1C00_0400, 17'd0, 1'b0, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1111_2222;
        step();
        data_sram_rdata = 32'h0;
        ws_reflush_ms   = 1'b1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_ws_valid got %b want 0", ms_to_ws_valid); end
        step();
        ws_reflush_ms = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_after_valid got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("[TB] FAIL flush_allowin got %b want 1", ms_allowin); end
        checks++; if (ms_to_ds_dest !== 5'd0) begin errors++; $display("[TB] FAIL flush_ds_dest got %0d want 0", ms_to_ds_dest); end
        // A fresh load must see live SRAM data, not the flushed buffer.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(5'b10000, 1'b1, 1'b1, 5'd4, 32'h0000_5004, 32'h1C00_0408, 17'd0, 1'b0, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h3333_4444;
        #1;
        checks++; if (ms_to_ws_bus[63:32] !== 32'h3333_4444) begin errors++; $display("[TB] FAIL flush_newload got %h want 33334444", ms_to_ws_bus[63:32]); end
        ws_allowin = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] alus[3] = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3};
        ws_allowin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = make_bus(5'b00000, 1'b0, 1'b1, 5'(10 + i), alus[i], 32'h1C00_0500 + 32'(4 * i), 17'd0, 1'b0, 1'b0);
            step();
            data_sram_rdata = 32'hFFFF_FFFF;
            #1;
            checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid_%0d got %b want 1", i, ms_to_ws_valid); end
            checks++; if (ms_to_ws_bus[63:32] !== alus[i]) begin errors++; $display("[TB] FAIL b2b_result_%0d got %h want %h", i, ms_to_ws_bus[63:32], alus[i]); end
            checks++; if (ms_to_ds_dest !== 5'(10 + i)) begin errors++; $display("[TB] FAIL b2b_dest_%0d got %0d want %0d", i, ms_to_ds_dest, 10 + i); end
            checks++; if (ms_csr !== 1'b0) begin errors++; $display("[TB] FAIL b2b_csr_%0d got %b want 0", i, ms_csr); end
        end
        es_to_ms_bus = make_bus(5'b00000, 1'b0, 1'b1, 5'd13, 32'h0, 32'h1C00_0600, 17'd0, 1'b0, 1'b1);
        step();
        es_to_ms_valid = 1'b0;
        #1;
        checks++; if (ms_csr !== 1'b1) begin errors++; $display("[TB] FAIL csr_rd got %b want 1", ms_csr); end
        step();
        checks++; if (ms_csr !== 1'b0) begin errors++; $display("[TB] FAIL csr_drain got %b want 0", ms_csr); end
    endtask

    task automatic test_reset_mid_load();
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(5'b10000, 1'b1, 1'b1, 5'd8, 32'h0000_6000, 32'h1C00_0700, 17'd0, 1'b0, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h5555_AAAA;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_to_ds_dest !== 5'd0) begin errors++; $display("[TB] FAIL rst_mid_dest got %0d want 0", ms_to_ds_dest); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_allowin got %b want 1", ms_allowin); end
        ws_allowin = 1'b1;
    endtask

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        ws_reflush_ms   = 1'b0;
        test_reset();
        test_load_word();
        test_load_align();
        test_stall();
        test_exception();
        test_flush();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
